fc_mac_engine: RTL and testbench
================================

Name: fc_mac_engine

Overview:
Fully-connected layer compute stage that drives the synchronous int8 FC weight ROM and consumes its data. It works in three steps:
- Buffers one input activation vector.
- Streams weights row by row, one MAC per cycle, into an accumulator.
- Requantizes each neuron result to int8 and emits it on a valid/ready output stream.

Default sizing is LeNet C5: 400 inputs × 120 outputs, matching the 48000-word weight image.

Parameters:
NUM_IN, 400, activations per input vector (weights per neuron row)
NUM_OUT, 120, output neurons per vector
ACC_W, 32, signed accumulator width
SHIFT, 8, arithmetic right shift applied at requantization
RELU, 1, 1 = clamp negative results to 0; 0 = signed saturation only

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  activation byte valid
in_ready  out  1  block accepts an activation (high only in LOAD)
in_data  in  8  signed activation
rom_addr  out  $clog2(NUM_IN*NUM_OUT)  weight ROM address; ROM returns data one cycle later
rom_q  in  8  signed weight from ROM (registered read)
out_valid  out  1  requantized neuron result valid
out_ready  in  1  downstream accepts result
out_data  out  8  signed int8 neuron result
out_last  out  1  high with the result of neuron NUM_OUT-1
busy  out  1  high in every state except LOAD

Behaviour:
- Reset values (asynchronous, while rst_n=0):
  - state=LOAD; in/neuron counters=0; rom_addr=0; acc=0; pipeline valid=0.
  - out_valid=0, out_data=0, out_last=0, busy=0, in_ready=1.
  - Activation buffer is not reset.
- LOAD:
  - in_ready=1. Each in_valid&in_ready cycle writes in_data to act[cnt] and increments cnt.
  - On the handshake with cnt=NUM_IN-1: cnt←0, rom_addr←0, acc←0, go to COMPUTE.
- COMPUTE (exactly NUM_IN cycles per neuron):
  - Each cycle presents rom_addr = neuron*NUM_IN + i.
  - Address is a running counter, incremented by 1 each cycle; no multiplier. It is contiguous across neurons.
  - act[i] and a pipeline-valid bit are registered alongside.
  - On the next cycle acc += sign-extended(rom_q × act_d) (16-bit product, signed).
  - After issuing i=NUM_IN-1 go to DRAIN.
- DRAIN (1 cycle):
  - Final product is added. At the closing edge: out_data←requant(acc + last product), out_valid←1, out_last←(neuron==NUM_OUT-1).
  - Go to EMIT.
  - out_valid therefore rises on the (NUM_IN+1)th rising edge after COMPUTE entry.
- requant(x):
  - y = x >>> SHIFT (arithmetic, floor).
  - If RELU and y<0 → 0.
  - If y>127 → 127; if y<-128 → -128.
- EMIT:
  - Hold out_valid, out_data and out_last stable; rom_addr is frozen; no MAC.
  - On out_valid&out_ready: out_valid←0, out_last←0, acc←0.
  - If it was the last neuron: neuron←0, go to LOAD.
  - Otherwise: neuron++ and return to COMPUTE; rom_addr continues from its held value + 1.
- in_valid outside LOAD is ignored (in_ready=0).
- Per-neuron period is NUM_IN+2 cycles when out_ready is held high.
- Accumulator wrap is not checked. ACC_W must be ≥ 16+$clog2(NUM_IN)+1.
- Reset mid-operation: immediate return to LOAD with all reset values.
  - The partial result is discarded and never emitted.
  - The next vector requires a full NUM_IN-byte reload.
- out_ready asserted while out_valid=0 has no effect.

Test Plan:
- Load 400×(+1); ROM all +1; SHIFT=0, RELU=1 → 120 outputs, each 127 (400 saturated); out_last only on the 120th; rom_addr visits 0..47999 exactly once, in order.
- Load 400×(+1); ROM row j = +1 for even j, −1 for odd j; SHIFT=2 → even neurons 100, odd neurons 0. Repeat with RELU=0 → odd neurons −100.
- Timing with out_ready tied high: first out_valid exactly 401 edges after the COMPUTE entry edge; successive outputs every 402 cycles; busy falls the cycle after the final handshake.
- Backpressure: hold out_ready low for 10 cycles at neuron 5 → out_valid and out_data stable, rom_addr constant (2399); results afterwards identical to the no-stall run.
- Rounding: acts=1, row 0 weights sum to −3 (e.g. −1,−1,−1, rest 0), SHIFT=1, RELU=0 → out_data=−2 (floor).
- Assert rst_n low for 1 cycle at COMPUTE i=200 → all outputs return to reset values, in_ready=1, no out_valid pulse; reload the vector, then a full 120-result run matches the reference model.

Source files
------------

// File: rtl/fc_mac_engine.sv
// Fully-connected layer MAC engine: buffers one int8 activation vector, streams
// weight rows from a registered-read ROM, and emits requantized int8 results.
module fc_mac_engine #(
  parameter int unsigned NUM_IN  = 400,
  parameter int unsigned NUM_OUT = 120,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned SHIFT   = 8,
  parameter int unsigned RELU    = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [7:0]                           in_data,
  output logic [$clog2(NUM_IN*NUM_OUT)-1:0]    rom_addr,
  input  logic [7:0]                           rom_q,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [7:0]                           out_data,
  output logic                                 out_last,
  output logic                                 busy
);

  localparam int unsigned ADDR_W = $clog2(NUM_IN * NUM_OUT);
  localparam int unsigned CNT_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int unsigned NRN_W  = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_IN - 1);
  localparam logic [NRN_W-1:0] NRN_LAST = NRN_W'(NUM_OUT - 1);
  localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] Q_MIN = ACC_W'(-128);

  typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN, EMIT} state_t;

  state_t                    state, state_n;
  logic [CNT_W-1:0]          cnt;
  logic [NRN_W-1:0]          neuron;
  logic signed [ACC_W-1:0]   acc;
  logic signed [7:0]         act_d;
  logic                      pv;
  logic signed [7:0]         act [NUM_IN];
  logic signed [15:0]        prod;
  logic signed [ACC_W-1:0]   acc_sum;
  logic signed [ACC_W-1:0]   shifted;
  logic [7:0]                rq;

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      LOAD:    if (in_valid && cnt == CNT_LAST) state_n = COMPUTE;
      COMPUTE: if (cnt == CNT_LAST) state_n = DRAIN;
      DRAIN:   state_n = EMIT;
      EMIT:    if (out_valid && out_ready) state_n = (neuron == NRN_LAST) ? LOAD : COMPUTE;
      default: state_n = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_n;
  end

  // Product of the weight returned this cycle and the activation issued with its address
  assign prod    = $signed(rom_q) * act_d;
  assign acc_sum = acc + (pv ? {{(ACC_W-16){prod[15]}}, prod} : '0);

  // Requantize: arithmetic shift (floor), optional ReLU, int8 saturation
  always_comb begin
    shifted = acc_sum >>> SHIFT;
    rq      = shifted[7:0];
    if (RELU != 0 && shifted < 0) rq = 8'd0;
    else if (shifted > Q_MAX)     rq = 8'h7f;
    else if (shifted < Q_MIN)     rq = 8'h80;
  end

  // Activation buffer is deliberately not reset
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid) act[cnt] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      neuron    <= '0;
      rom_addr  <= '0;
      acc       <= '0;
      act_d     <= '0;
      pv        <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      in_ready <= (state_n == LOAD);
      busy     <= (state_n != LOAD);
      pv       <= 1'b0;
      unique case (state)
        LOAD: begin
          if (in_valid) begin
            if (cnt == CNT_LAST) begin
              cnt      <= '0;
              rom_addr <= '0;
              acc      <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        COMPUTE: begin
          act_d <= act[cnt];
          pv    <= 1'b1;
          acc   <= acc_sum;
          // Address holds on the row's last weight and resumes after the handshake
          if (cnt == CNT_LAST) begin
            cnt <= '0;
          end else begin
            cnt      <= cnt + CNT_W'(1);
            rom_addr <= rom_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          acc       <= acc_sum;
          out_data  <= rq;
          out_valid <= 1'b1;
          out_last  <= (neuron == NRN_LAST);
        end
        EMIT: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            acc       <= '0;
            if (neuron == NRN_LAST) begin
              neuron <= '0;
            end else begin
              neuron   <= neuron + NRN_W'(1);
              rom_addr <= rom_addr + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_mac_engine.sv
// Directed bench for fc_mac_engine: two scaled-down instances (ReLU on/off)
// share stimulus and a weight memory; expected results are hand-computed.
module tb_fc_mac_engine;

  localparam int unsigned NI = 8;
  localparam int unsigned NO = 6;
  localparam int unsigned AW = $clog2(NI * NO);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, out_ready;
  logic [7:0]    in_data;
  logic          in_ready_a, in_ready_b, out_valid_a, out_valid_b;
  logic          out_last_a, out_last_b, busy_a, busy_b;
  logic [AW-1:0] rom_addr_a, rom_addr_b;
  logic [7:0]    rom_q_a, rom_q_b, out_data_a, out_data_b;
  logic [7:0]    wmem [NI*NO];

  always #5 clk = ~clk;

  fc_mac_engine #(.NUM_IN(NI), .NUM_OUT(NO), .ACC_W(32), .SHIFT(1), .RELU(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .rom_addr(rom_addr_a), .rom_q(rom_q_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .out_last(out_last_a), .busy(busy_a));

  fc_mac_engine #(.NUM_IN(NI), .NUM_OUT(NO), .ACC_W(32), .SHIFT(1), .RELU(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .rom_addr(rom_addr_b), .rom_q(rom_q_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .out_last(out_last_b), .busy(busy_b));

  // Registered-read weight ROM
  always @(posedge clk) begin
    rom_q_a <= wmem[rom_addr_a];
    rom_q_b <= wmem[rom_addr_b];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Address walk monitor: every change must be +1 or a restart at 0
  logic [AW-1:0] prev_addr = '0;
  int steps = 0;
  int bad_steps = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (rom_addr_a != prev_addr) begin
        if (rom_addr_a == prev_addr + AW'(1)) steps++;
        else if (rom_addr_a != '0)            bad_steps++;
      end
      prev_addr = rom_addr_a;
    end
  end

  typedef struct {
    int a;
    int nz;
    int w[NO];
    int ea[NO];
    int eb[NO];
  } vec_t;
  vec_t tbl[4];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic load_vec(input int v, output int entry);
    for (int j = 0; j < int'(NO); j++)
      for (int k = 0; k < int'(NI); k++)
        wmem[j*NI + k] = (k < tbl[v].nz) ? 8'(tbl[v].w[j]) : 8'd0;
    chk("load_in_ready", int'(in_ready_a), 1);
    for (int i = 0; i < int'(NI); i++) begin
      in_valid = 1'b1;
      in_data  = 8'(tbl[v].a);
      @(negedge clk);
    end
    in_valid = 1'b0;
    entry    = cyc;
  endtask

  task automatic collect(input int v, input int stall, input int entry);
    int t_start = entry;
    int s0      = steps;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    chk("compute_in_ready", int'(in_ready_a), 0);
    chk("compute_busy", int'(busy_a), 1);
    for (int n = 0; n < int'(NO); n++) begin
      int k = 0;
      while (!out_valid_a && k < 100) begin
        @(negedge clk);
        k++;
      end
      if (!out_valid_a) begin
        chk("out_valid_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      if (n == int'(NO) - 1) in_valid = 1'b0;
      chk("latency", cyc - t_start, int'(NI) + 1);
      chk("data_relu", int'($signed(out_data_a)), tbl[v].ea[n]);
      chk("data_sat", int'($signed(out_data_b)), tbl[v].eb[n]);
      chk("valid_b", int'(out_valid_b), 1);
      chk("out_last", int'(out_last_a), (n == int'(NO) - 1) ? 1 : 0);
      if (n == stall) begin
        out_ready = 1'b0;
        repeat (10) begin
          @(negedge clk);
          chk("stall_valid", int'(out_valid_a), 1);
          chk("stall_data", int'($signed(out_data_a)), tbl[v].ea[n]);
          chk("stall_addr", int'(rom_addr_a), n*int'(NI) + int'(NI) - 1);
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
      t_start = cyc;
      chk("valid_drop", int'(out_valid_a), 0);
    end
    chk("final_busy", int'(busy_a), 0);
    chk("final_in_ready", int'(in_ready_a), 1);
    chk("addr_steps", steps - s0, int'(NI*NO) - 1);
    chk("addr_order", bad_steps, 0);
  endtask

  initial begin
    int e;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    for (int i = 0; i < int'(NI*NO); i++) wmem[i] = '0;

    tbl[0].a = 1;   tbl[0].nz = 8; tbl[0].w = '{1, -1, 1, -1, 1, -1};
    tbl[0].ea = '{4, 0, 4, 0, 4, 0};         tbl[0].eb = '{4, -4, 4, -4, 4, -4};
    tbl[1].a = 127; tbl[1].nz = 8; tbl[1].w = '{127, -128, 1, -1, 0, 16};
    tbl[1].ea = '{127, 0, 127, 0, 0, 127};   tbl[1].eb = '{127, -128, 127, -128, 0, 127};
    tbl[2].a = 1;   tbl[2].nz = 3; tbl[2].w = '{-1, 1, -1, 3, -5, 0};
    tbl[2].ea = '{0, 1, 0, 4, 0, 0};         tbl[2].eb = '{-2, 1, -2, 4, -8, 0};
    tbl[3].a = -2;  tbl[3].nz = 8; tbl[3].w = '{-16, 16, -15, 15, -17, 17};
    tbl[3].ea = '{127, 0, 120, 0, 127, 0};   tbl[3].eb = '{127, -128, 120, -120, 127, -128};

    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(in_ready_a), 1);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_out_valid", int'(out_valid_a), 0);
    chk("rst_out_data", int'(out_data_a), 0);
    chk("rst_out_last", int'(out_last_a), 0);
    chk("rst_rom_addr", int'(rom_addr_a), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      load_vec(v, e);
      collect(v, -1, e);
    end

    // Backpressure on neuron 2; results must match the unstalled run
    load_vec(1, e);
    collect(1, 2, e);

    // Reset in the middle of a row, then a fresh full vector
    load_vec(0, e);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", int'(in_ready_a), 1);
    chk("mid_rst_busy", int'(busy_a), 0);
    chk("mid_rst_out_valid", int'(out_valid_a), 0);
    chk("mid_rst_rom_addr", int'(rom_addr_a), 0);
    chk("mid_rst_out_last", int'(out_last_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", int'(out_valid_a), 0);
    load_vec(2, e);
    collect(2, -1, e);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
